// File: rtl/mips_loader_pkg.sv
// Shared constants and state encoding for the MIPS instruction loader.
package mips_loader_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory load port of instr_loader.
// master drives start/bytes and observes the load port; slave is the loader.
interface instr_loader_if
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) ();

  localparam int CNT_W = $clog2(MEM_DEPTH) + 1;

  logic                  i_start;
  logic [BYTE_WIDTH-1:0] i_rx_data;
  logic                  i_rx_valid;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;
  logic [CNT_W-1:0]      o_word_count;
  logic                  o_done;
  logic                  o_overflow;
  logic                  o_checksum_err;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_instruccion, o_address, o_loading, o_word_count,
           o_done, o_overflow, o_checksum_err
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_instruccion, o_address, o_loading, o_word_count,
           o_done, o_overflow, o_checksum_err
  );

endinterface

// File: rtl/instr_loader_byte_assembler.sv
// byte_assembler: packs accepted bytes MSB-first into a word and flags the
// cycle in which the last byte of a word arrives.
module byte_assembler
  import mips_loader_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 accept,
  input  logic [BYTE_WIDTH-1:0]                rx_data,
  output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word,
  output logic                                 word_valid
);

  localparam int SHIFT_W = BYTE_WIDTH * (BYTES_PER_WORD - 1);
  localparam int CNT_W   = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [SHIFT_W-1:0] shift;
  logic [CNT_W-1:0]   byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      shift    <= {shift[SHIFT_W-BYTE_WIDTH-1:0], rx_data};
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // The word is complete combinationally with its last byte, so the loader
  // can register it on the same edge the byte is taken.
  assign word       = {shift, rx_data};
  assign word_valid = accept && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/instr_loader.sv
// instr_loader: loads a serial byte stream into TOP_MIPS instruction memory.
// Optional checksum trailer byte enabled by macro LOADER_CHECKSUM_EN.
//
//   state | meaning
//   IDLE  | no session yet, bytes ignored
//   RECV  | collecting bytes of the current word
//   WRITE | single o_loading cycle for the assembled word
//   CHECK | waiting for the checksum byte after HALT (LOADER_CHECKSUM_EN)
//   DONE  | session finished, outputs hold until the next i_start
module instr_loader
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(DEFAULT_HALT_WORD)
) (
  input logic           i_clock,
  input logic           i_reset,
  instr_loader_if.slave bus
);

  localparam int CNT_W  = $clog2(MEM_DEPTH) + 1;
  localparam int WORD_W = BYTE_WIDTH * BYTES_PER_WORD;
  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_DEPTH - 1);

  state_t                state, state_nxt;
  logic                  start_session;
  logic                  byte_accept;
  logic                  word_valid;
  logic [WORD_W-1:0]     word;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] addr;
  logic [CNT_W-1:0]      word_count;
  logic                  overflow;
  logic                  is_halt;
  logic                  at_last;
  logic                  write_continues;

  assign is_halt         = (instr == HALT_WORD);
  assign at_last         = (addr == LAST_ADDR);
  assign write_continues = !is_halt && !at_last;

  // A byte arriving in WRITE belongs to the next word only if the session goes on.
  assign byte_accept = bus.i_rx_valid &&
                       ((state == RECV) || ((state == WRITE) && write_continues));

  byte_assembler u_byte_assembler (
    .clk        (i_clock),
    .rst        (i_reset),
    .clear      (start_session),
    .accept     (byte_accept),
    .rx_data    (bus.i_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    start_session = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_nxt     = RECV;
          start_session = 1'b1;
        end
      end
      RECV: begin
        if (word_valid) state_nxt = WRITE;
      end
      WRITE: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else if (at_last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (bus.i_rx_valid) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      instr      <= '0;
      addr       <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (start_session) begin
        addr       <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (word_valid) instr <= DATA_WIDTH'(word);
      if (state == WRITE) begin
        word_count <= word_count + CNT_W'(1);
        if (!is_halt) begin
          if (at_last) overflow <= 1'b1;
          else         addr     <= addr + DATA_WIDTH'(1);
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] run_xor;
  logic                  checksum_err;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      run_xor      <= '0;
      checksum_err <= 1'b0;
    end else begin
      if (start_session) begin
        run_xor      <= '0;
        checksum_err <= 1'b0;
      end else if (byte_accept) begin
        run_xor <= run_xor ^ bus.i_rx_data;
      end
      if ((state == CHECK) && bus.i_rx_valid) checksum_err <= (bus.i_rx_data != run_xor);
    end
  end

  assign bus.o_checksum_err = checksum_err;
`else
  assign bus.o_checksum_err = 1'b0;
`endif

  assign bus.o_instruccion = instr;
  assign bus.o_address     = addr;
  assign bus.o_loading     = (state == WRITE) && !i_reset;
  assign bus.o_word_count  = word_count;
  assign bus.o_done        = (state == DONE);
  assign bus.o_overflow    = overflow;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed programs plus random sessions
// compared every cycle against a word-level reference model.
module tb_instr_loader;
  import mips_loader_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic       rv;
  logic [7:0] rd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 1'b0;
  wr_t wlog[$];

  instr_loader_if #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) bus ();

  assign bus.i_start    = st;
  assign bus.i_rx_valid = rv;
  assign bus.i_rx_data  = rd;

  instr_loader #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: session flags, collected bytes and the pending write.
  logic [7:0]  part[$];
  bit          m_active, m_await, m_pend, m_done, m_ovf, m_err;
  bit          was_wr, can_start;
  logic [31:0] m_instr;
  logic [7:0]  m_xor;
  int          m_addr, m_count;

  initial begin
    m_active = 0; m_await = 0; m_pend = 0; m_done = 0; m_ovf = 0; m_err = 0;
    m_instr = '0; m_xor = '0; m_addr = 0; m_count = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_active = 0; m_await = 0; m_pend = 0; m_done = 0; m_ovf = 0; m_err = 0;
      m_instr = '0; m_xor = '0; m_addr = 0; m_count = 0;
      part.delete();
    end else begin
      was_wr    = m_pend;
      can_start = !m_active && !m_await && !was_wr;
      m_pend    = 0;
      if (m_await && rv) begin
        m_err   = (rd != m_xor);
        m_await = 0;
        m_done  = 1;
      end else begin
        if (was_wr) begin
          m_count++;
          if (m_instr == HALT) begin
            m_active = 0;
            if (CK) m_await = 1;
            else    m_done  = 1;
          end else if (m_addr == DEPTH - 1) begin
            m_active = 0; m_ovf = 1; m_done = 1;
          end else begin
            m_addr++;
          end
        end
        if (m_active && rv) begin
          m_xor ^= rd;
          part.push_back(rd);
          if (part.size() == 4) begin
            m_instr = {part[0], part[1], part[2], part[3]};
            m_pend  = 1;
            part.delete();
          end
        end
      end
      if (can_start && st) begin
        m_active = 1; m_done = 0; m_ovf = 0; m_err = 0;
        m_addr = 0; m_count = 0; m_xor = '0;
        part.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("loading", 32'(bus.o_loading), 32'(m_pend && !rst));
      if (bus.o_loading) wlog.push_back('{bus.o_address, bus.o_instruccion, cyc});
      chk("instruccion", bus.o_instruccion, m_instr);
      chk("address", bus.o_address, 32'(m_addr));
      chk("word_count", 32'(bus.o_word_count), 32'(m_count));
      chk("done", 32'(bus.o_done), 32'(m_done));
      chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
      chk("checksum_err", 32'(bus.o_checksum_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rv = 1'b1;
    rd = b;
    tick();
    rv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 3; b >= 0; b--) begin
      send(w[8*b +: 8]);
      idle(gap);
    end
  endtask

  task automatic start_pulse();
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  int          c0;
  int          nw;
  logic [31:0] w;

  initial begin
    rst = 1'b1; st = 1'b0; rv = 1'b0; rd = '0;
    tick();
    started = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_loading", 32'(bus.o_loading), 0);
    chk("rst_count", 32'(bus.o_word_count), 0);
    chk("rst_instr", bus.o_instruccion, 0);

    // Simple two-word program ending in HALT.
    wlog.delete();
    start_pulse();
    send_word(32'h2001_0005, 1);
    send_word(HALT, 1);
    idle(2);
    if (CK) begin send(8'h24); idle(2); end
    chk("t1_nwrites", 32'(wlog.size()), 2);
    chk("t1_w0_addr", wlog[0].addr, 0);
    chk("t1_w0_data", wlog[0].data, 32'h2001_0005);
    chk("t1_w1_addr", wlog[1].addr, 1);
    chk("t1_w1_data", wlog[1].data, HALT);
    chk("t1_done", 32'(bus.o_done), 1);
    chk("t1_count", 32'(bus.o_word_count), 2);
    chk("t1_overflow", 32'(bus.o_overflow), 0);
    chk("t1_model_count", 32'(m_count), 2);

    // Bytes before i_start are ignored.
    reset_pulse(1);
    wlog.delete();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(1);
    start_pulse();
    send_word(32'h8C22_0004, 0);
    send_word(HALT, 0);
    idle(2);
    if (CK) begin send(8'hAA); idle(2); end
    chk("t2_nwrites", 32'(wlog.size()), 2);
    chk("t2_w0_addr", wlog[0].addr, 0);
    chk("t2_w0_data", wlog[0].data, 32'h8C22_0004);

    // Memory fills before HALT.
    wlog.delete();
    start_pulse();
    for (int i = 1; i <= 5; i++) send_word(32'(i), 1);
    idle(3);
    chk("t3_nwrites", 32'(wlog.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", wlog[i].addr, 32'(i));
      chk("t3_data", wlog[i].data, 32'(i + 1));
    end
    chk("t3_overflow", 32'(bus.o_overflow), 1);
    chk("t3_done", 32'(bus.o_done), 1);
    chk("t3_count", 32'(bus.o_word_count), 4);
    chk("t3_checksum_err", 32'(bus.o_checksum_err), 0);
    chk("t3_model_ovf", 32'(m_ovf), 1);

    // Reset mid-word discards the partial word.
    wlog.delete();
    start_pulse();
    send(8'h12); send(8'h34);
    reset_pulse(1);
    start_pulse();
    send_word(32'h8C22_0004, 1);
    idle(2);
    chk("t4_nwrites", 32'(wlog.size()), 1);
    chk("t4_w0_addr", wlog[0].addr, 0);
    chk("t4_w0_data", wlog[0].data, 32'h8C22_0004);
    chk("t4_count", 32'(bus.o_word_count), 1);

    // Back-to-back bytes: strobes four cycles apart, none lost.
    reset_pulse(1);
    wlog.delete();
    start_pulse();
    rv = 1'b1; rd = 8'h01;
    c0 = cyc;
    tick();
    rd = 8'h02; tick();
    rd = 8'h03; tick();
    rd = 8'h04; tick();
    for (int i = 0; i < 4; i++) begin rd = 8'hFF; tick(); end
    rv = 1'b0;
    idle(2);
    if (CK) begin send(8'h04); idle(2); end
    chk("t5_nwrites", 32'(wlog.size()), 2);
    chk("t5_w0_cyc", 32'(wlog[0].cyc - c0), 4);
    chk("t5_w1_cyc", 32'(wlog[1].cyc - c0), 8);
    chk("t5_w0_data", wlog[0].data, 32'h0102_0304);
    chk("t5_w1_data", wlog[1].data, HALT);

`ifdef LOADER_CHECKSUM_EN
    for (int run = 0; run < 2; run++) begin
      reset_pulse(1);
      start_pulse();
      send_word(32'h0102_0304, 1);
      send_word(HALT, 1);
      idle(2);
      chk("t6_done_before_ck", 32'(bus.o_done), 0);
      send(run == 0 ? 8'h04 : 8'h05);
      idle(1);
      chk("t6_done", 32'(bus.o_done), 1);
      chk("t6_checksum_err", 32'(bus.o_checksum_err), 32'(run));
    end
`endif

    // Random sessions: gaps, stray starts, junk bytes, occasional resets.
    reset_pulse(1);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) send(8'($urandom));
      start_pulse();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        w = (k == nw - 1 && $urandom_range(0, 2) != 0) ? HALT : $urandom;
        for (int b = 3; b >= 0; b--) begin
          if ($urandom_range(0, 15) == 0) st = 1'b1;
          send(w[8*b +: 8]);
          st = 1'b0;
          if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        if ($urandom_range(0, 19) == 0) reset_pulse(1);
      end
      idle(2);
      send(($urandom_range(0, 1) == 1) ? m_xor : 8'($urandom));
      idle(2);
      if (s % 8 == 7) reset_pulse(1);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Feeds the MIPS core's instruction-memory load port, driving i_instruccion, i_address and i_loading on TOP_MIPS.
- Accepts a byte stream from the serial receiver and assembles four bytes into each 32-bit instruction, most-significant byte first.
- Writes each instruction to consecutive word addresses and stops on a HALT word or when memory is full.
- Sits between the UART RX block and TOP_MIPS, and tells the debug/control logic when the program is loaded.

Parameters:
DATA_WIDTH, 32, instruction and address width
MEM_DEPTH, 256, instruction memory depth in words (power of two, >= 2)
HALT_WORD, 32'hFFFFFFFF, word that terminates a program (it is itself written)

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse that begins a load session
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe meaning i_rx_data is valid
o_instruccion  out  DATA_WIDTH  assembled instruction, goes to TOP_MIPS i_instruccion
o_address  out  DATA_WIDTH  word address, goes to TOP_MIPS i_address
o_loading  out  1  one-cycle write strobe, goes to TOP_MIPS i_loading
o_word_count  out  $clog2(MEM_DEPTH)+1  number of words written in this session
o_done  out  1  load session finished (level)
o_overflow  out  1  memory filled before HALT_WORD arrived (level)
o_checksum_err  out  1  checksum mismatch (see Optional Feature)

Behaviour:
- Reset: state IDLE; byte counter, shift register, all outputs = 0.
- Reset mid-session discards any partial word; no o_loading pulse occurs on or after the reset cycle.
- States: IDLE, RECV, WRITE, DONE (plus CHECK when the optional feature is enabled).
- IDLE:
  - Bytes are ignored.
  - i_start -> RECV; clears o_address, o_word_count, o_done, o_overflow, o_checksum_err and the byte counter.
- RECV:
  - On each i_rx_valid: shift <= {shift[23:0], i_rx_data}; byte_cnt++ (2 bits, wraps at 4).
  - On the 4th byte: o_instruccion <= {shift[23:0], i_rx_data} and go to WRITE.
- WRITE (exactly one cycle):
  - o_loading = 1, carrying o_instruccion and o_address.
  - Latency: 4th-byte strobe in cycle N gives o_loading high in cycle N+1 only.
- Leaving WRITE:
  - If o_instruccion == HALT_WORD: o_word_count++ and go to DONE.
  - Else, if o_address == MEM_DEPTH-1: o_word_count++, o_overflow <= 1, go to DONE.
  - Else: o_address++, o_word_count++, back to RECV.
- Simultaneous events: an i_rx_valid during WRITE is accepted as byte 0 of the next word, so back-to-back bytes every cycle are never lost.
- DONE:
  - o_done = 1 and o_loading = 0.
  - Bytes are ignored; outputs hold.
  - i_start -> new session as from IDLE.
- i_start while in RECV or WRITE is ignored.
- Address arithmetic: o_address never exceeds MEM_DEPTH-1 and never wraps.
- o_word_count counts writes including the HALT word.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every program byte, including the HALT word bytes; it is cleared on i_start.
  - After the HALT word write, go to CHECK, which waits for one more i_rx_valid byte.
  - o_checksum_err <= (byte != running XOR), then go to DONE.
  - o_done rises only after the checksum byte.
  - On overflow, CHECK is skipped and o_checksum_err stays 0.
- Undefined: no CHECK state and no XOR register; o_checksum_err is tied to 0.

Decomposition:
- Package mips_loader_pkg holds:
  - the state encoding constants (IDLE, RECV, WRITE, DONE, CHECK);
  - BYTE_WIDTH = 8;
  - BYTES_PER_WORD = 4;
  - the default HALT_WORD.
- One sub-module, byte_assembler:
  - contains the shift register and the 2-bit byte counter;
  - outputs the word plus a one-cycle word_valid;
  - instr_loader keeps the FSM, address and count logic.

Test Plan:
1. Reset, i_start, then bytes 20 01 00 05 followed by FF FF FF FF:
   - o_loading pulses at addr 0 with 0x20010005, then at addr 1 with 0xFFFFFFFF;
   - o_done=1, o_word_count=2, o_overflow=0.
2. Bytes AA BB CC DD sent before i_start, then a normal program:
   - the early bytes are ignored;
   - the first write is at addr 0 with the post-start data.
3. MEM_DEPTH=4, five non-HALT words (0x00000001..0x00000005):
   - writes at addr 0..3 only;
   - o_overflow=1, o_done=1, o_word_count=4;
   - no write of 0x00000005.
4. Bytes 12 34 sent, i_reset asserted for one cycle, i_start, then 8C 22 00 04:
   - the single write is at addr 0 with 0x8C220004;
   - no pulse occurs during or after the reset.
5. Eight bytes with i_rx_valid high on consecutive cycles 1..8 (01 02 03 04 FF FF FF FF):
   - o_loading in cycles 5 and 9;
   - data 0x01020304 then 0xFFFFFFFF.
6. With LOADER_CHECKSUM_EN, program 01 02 03 04 FF FF FF FF:
   - checksum byte 04 gives o_checksum_err=0;
   - rerunning with checksum byte 05 gives o_checksum_err=1;
   - in both runs o_done rises only after the checksum byte.
